round_robin_arbiter_4: RTL and testbench

Four-requester round-robin arbiter that shares one 2:4-decoded resource (e.g. one bank or bus selected by a 2-bit index) between requesters 0..3. It registers a 2-bit grant index and drives a matching one-hot grant. It enforces a maximum ownership time and hands over back-to-back with no idle cycle when other requests are pending. It sits between the requesters and the resource's select/decode logic.

---
 rtl/round_robin_arbiter_4.sv | 135 +++++++++++++
 tb/tb_round_robin_arbiter_4.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter_4.sv
// Four-requester round-robin arbiter with a registered grant index, a per-owner
// hold limit and zero-bubble handover between owners.
module round_robin_arbiter_4 #(
  parameter int unsigned MAX_HOLD_CYCLES  = 16,
  parameter int unsigned HOLD_COUNT_WIDTH = 8
) (
  input  logic       Clock_In,
  input  logic       Reset_In,
  input  logic       Enable_In,
  input  logic [3:0] Request_In,
  output logic       Grant_Valid_Out,
  output logic [1:0] Grant_Index_Out,
  output logic       Grant_0_Out,
  output logic       Grant_1_Out,
  output logic       Grant_2_Out,
  output logic       Grant_3_Out,
  output logic       Timeout_Out
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_e;

  localparam logic [HOLD_COUNT_WIDTH-1:0] HOLD_MAX = HOLD_COUNT_WIDTH'(MAX_HOLD_CYCLES);
  localparam logic [HOLD_COUNT_WIDTH-1:0] HOLD_ONE = HOLD_COUNT_WIDTH'(1);

  state_e                      state_q, state_d;
  logic [1:0]                  last_q, last_d;
  logic [1:0]                  idx_q, idx_d;
  logic [HOLD_COUNT_WIDTH-1:0] hold_q, hold_d;
  logic                        timeout_q, timeout_d;

  logic [3:0] handover_mask;
  logic [2:0] pick_req;
  logic [2:0] pick_handover;
  logic       owner_req;
  logic       at_limit;
  logic [3:0] grant_vec;

  // Returns {found, winner}: first set bit scanning last+1 .. last+4 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] last);
    logic       found;
    logic [1:0] win;
    logic [1:0] cand;
    found = 1'b0;
    win   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && mask[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    return {found, win};
  endfunction

  // The owner's own bit is excluded so a released owner cannot immediately win again.
  assign owner_req     = Request_In[idx_q];
  assign handover_mask = Request_In & ~(4'b0001 << idx_q);
  assign pick_req      = rr_pick(Request_In, last_q);
  assign pick_handover = rr_pick(handover_mask, idx_q);
  assign at_limit      = (hold_q >= HOLD_MAX);

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q   <= ST_IDLE;
      last_q    <= 2'd3;
      idx_q     <= 2'd0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Enable_In && pick_req[2]) begin
          state_d = ST_GRANTED;
          idx_d   = pick_req[1:0];
          hold_d  = HOLD_ONE;
        end
      end
      ST_GRANTED: begin
        if (Enable_In && owner_req && !at_limit) begin
          hold_d = hold_q + HOLD_ONE;
        end else begin
          // Disable wins over timeout, so the pulse needs Enable_In high.
          last_d    = idx_q;
          timeout_d = Enable_In && owner_req;
          if (Enable_In && pick_handover[2]) begin
            idx_d  = pick_handover[1:0];
            hold_d = HOLD_ONE;
          end else begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            hold_d  = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    Grant_Valid_Out = (state_q == ST_GRANTED);
    Grant_Index_Out = idx_q;
    Timeout_Out     = timeout_q;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_grant
    assign grant_vec[gi] = Grant_Valid_Out && (idx_q == 2'(gi));
  end

  assign Grant_0_Out = grant_vec[0];
  assign Grant_1_Out = grant_vec[1];
  assign Grant_2_Out = grant_vec[2];
  assign Grant_3_Out = grant_vec[3];

endmodule

// File: tb/tb_round_robin_arbiter_4.sv
// Bench for round_robin_arbiter_4: directed scenarios plus random traffic checked
// cycle by cycle against an integer reference model and fairness/hold bounds.
module tb_round_robin_arbiter_4;

  localparam int MAXH       = 4;
  localparam int FAIR_BOUND = 3 * MAXH + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       g_valid;
  logic [1:0] g_idx;
  logic       g0, g1, g2, g3;
  logic       tmo;

  round_robin_arbiter_4 #(
    .MAX_HOLD_CYCLES (MAXH),
    .HOLD_COUNT_WIDTH(8)
  ) dut (
    .Clock_In       (clk),
    .Reset_In       (rst),
    .Enable_In      (en),
    .Request_In     (req),
    .Grant_Valid_Out(g_valid),
    .Grant_Index_Out(g_idx),
    .Grant_0_Out    (g0),
    .Grant_1_Out    (g1),
    .Grant_2_Out    (g2),
    .Grant_3_Out    (g3),
    .Timeout_Out    (tmo)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner as an integer (-1 = nobody), plain modular search.
  int m_owner = -1;
  int m_last  = 3;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  int wait_cnt[4];
  int run_len    = 0;
  int prev_valid = 0;
  int prev_idx   = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rr_winner(input logic [3:0] mask, input int from);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input bit r, input bit e, input logic [3:0] q);
    if (r) begin
      m_owner = -1; m_last = 3; m_hold = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      if (e && q != 4'b0000) begin
        m_owner = rr_winner(q, m_last);
        m_hold  = 1;
      end
    end else begin
      int         o;
      int         w;
      logic [3:0] nq;
      o = m_owner;
      if (e && q[o] && m_hold < MAXH) begin
        m_hold++;
        m_to = 1'b0;
      end else begin
        m_to   = e && q[o];
        m_last = o;
        nq     = q;
        nq[o]  = 1'b0;
        w      = rr_winner(nq, o);
        if (e && w >= 0) begin
          m_owner = w; m_hold = 1;
        end else begin
          m_owner = -1; m_hold = 0;
        end
      end
    end
  endtask

  // One clock: drive on negedge, update model at posedge, compare 1 ns later.
  task automatic tick(input bit r, input bit e, input logic [3:0] q);
    logic [3:0] gv;
    @(negedge clk);
    rst = r; en = e; req = q;
    @(posedge clk);
    model_step(r, e, q);
    #1;
    gv = {g3, g2, g1, g0};
    check_value("valid", 32'(g_valid), 32'(m_owner >= 0));
    check_value("index", 32'(g_idx), 32'((m_owner >= 0) ? m_owner : 0));
    check_value("grant_vec", 32'(gv), 32'((m_owner >= 0) ? (1 << m_owner) : 0));
    check_value("timeout", 32'(tmo), 32'(m_to));

    if (g_valid && prev_valid != 0 && int'(g_idx) == prev_idx) run_len++;
    else run_len = g_valid ? 1 : 0;
    prev_valid = int'(g_valid);
    prev_idx   = int'(g_idx);
    check_value("hold_bound", 32'(run_len <= MAXH), 32'd1);

    for (int k = 0; k < 4; k++) begin
      if (r || !e || !q[k] || gv[k]) wait_cnt[k] = 0;
      else wait_cnt[k]++;
      check_value($sformatf("fair_%0d", k), 32'(wait_cnt[k] <= FAIR_BOUND), 32'd1);
    end
  endtask

  int         order_q[$];
  logic [3:0] q;
  logic [3:0] rq;
  bit         e_r;
  bit         r_r;

  initial begin
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;

    // Reset, then a lone request from requester 0.
    tick(1'b1, 1'b1, 4'b0000);
    check_value("rst_valid", 32'(g_valid), 32'd0);
    check_value("rst_grants", 32'({g3, g2, g1, g0}), 32'd0);
    check_value("rst_timeout", 32'(tmo), 32'd0);
    tick(1'b0, 1'b1, 4'b0001);
    check_value("tp1_grant0", 32'(g0), 32'd1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 4'b0001);
    tick(1'b0, 1'b1, 4'b0000);
    check_value("tp1_release", 32'(g_valid), 32'd0);

    // All requesting, each owner drops after three granted cycles.
    tick(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 14; i++) begin
      q = 4'b1111;
      if (m_owner >= 0 && m_hold == 3) q[m_owner] = 1'b0;
      tick(1'b0, 1'b1, q);
      check_value("tp2_timeout", 32'(tmo), 32'd0);
      if (i > 0) check_value("tp2_no_bubble", 32'(g_valid), 32'd1);
      if (g_valid && (order_q.size() == 0 || order_q[$] != int'(g_idx))) order_q.push_back(int'(g_idx));
    end
    check_value("tp2_order_len", 32'(order_q.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < order_q.size(); i++)
      check_value($sformatf("tp2_order_%0d", i), 32'(order_q[i]), 32'(i % 4));

    // Two requesters held: alternate with timeout pulses.
    tick(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 18; i++) tick(1'b0, 1'b1, 4'b0110);
    // Lone requester held: four granted, one idle cycle with timeout.
    tick(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 4'b1000);
    check_value("tp4_idle", 32'(g_valid), 32'd0);
    check_value("tp4_pulse", 32'(tmo), 32'd1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 4'b1000);

    // Disable release of owner 2, then search resumes from 3.
    tick(1'b1, 1'b1, 4'b0000);
    tick(1'b0, 1'b1, 4'b0100);
    tick(1'b0, 1'b0, 4'b0100);
    check_value("tp5_off", 32'(g_valid), 32'd0);
    check_value("tp5_no_pulse", 32'(tmo), 32'd0);
    tick(1'b0, 1'b1, 4'b0101);
    check_value("tp5_index", 32'(g_idx), 32'd0);

    // Reset mid-grant.
    tick(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 4'b0010);
    tick(1'b1, 1'b1, 4'b0010);
    check_value("tp6_rst", 32'({g_valid, g_idx, g3, g2, g1, g0, tmo}), 32'd0);
    tick(1'b0, 1'b1, 4'b1010);
    check_value("tp6_index", 32'(g_idx), 32'd1);

    // Random traffic: sticky requests, rare disables and resets.
    rq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(7) == 0) rq[k] = ~rq[k];
      e_r = ($urandom_range(31) != 0);
      r_r = ($urandom_range(255) == 0);
      tick(r_r, e_r, rq);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
